// File: rtl/pacote_pkg.sv
// pacote_pkg: packet field layout, channel count and receiver FSM state type.
package pacote_pkg;
    localparam int ADDR_MSB = 10;
    localparam int ADDR_LSB = 8;
    localparam int DATA_MSB = 7;
    localparam int DATA_LSB = 0;
    localparam int PACOTE_W = 11;
    localparam int N_CANAIS = 8;
    typedef enum logic [2:0] {OCIOSO, VERIFICA, GRAVA, REENVIO, DESCARTA} estado_t;
endpackage

// File: rtl/calc_paridade.sv
// calc_paridade: even-parity bit expected for an 8-bit data byte.
module calc_paridade (
    input  logic [7:0] dado_i,
    output logic       paridade_o
);
    assign paridade_o = ^dado_i;
endmodule

// File: rtl/receptor_pacote.sv
// receptor_pacote: parity-checked packet receiver with 8 channel registers and retry/discard FSM.
// Optional CONTADOR_ERROS_EN adds a saturating count of cycles spent in REENVIO/DESCARTA.
module receptor_pacote
    import pacote_pkg::*;
#(
    parameter int MAX_TENTATIVAS = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [PACOTE_W-1:0]     pacote,
    input  logic                    paridade,
    input  logic                    pacote_valido,
    output logic                    pacote_pronto,
    output logic                    solicitar_reenvio,
    output logic [N_CANAIS*8-1:0]   saida_canais,
    output logic [N_CANAIS-1:0]     canal_atualizado,
`ifdef CONTADOR_ERROS_EN
    output logic [7:0]              contagem_erros,
`endif
    output logic [N_CANAIS-1:0]     erro_persistente
);
    estado_t                 estado_q, estado_d;
    logic [PACOTE_W-1:0]     pacote_q;
    logic                    paridade_q;
    logic [2:0]              tentativas_q, tentativas_d;
    logic [N_CANAIS*8-1:0]   canais_q, canais_d;
    logic [N_CANAIS-1:0]     atualizado_q, atualizado_d;
    logic [N_CANAIS-1:0]     erro_q, erro_d;
    logic                    pronto_q, reenvio_q;
    logic                    paridade_calc;
    logic [2:0]              addr;
    logic [7:0]              dado;

    assign addr = pacote_q[ADDR_MSB:ADDR_LSB];
    assign dado = pacote_q[DATA_MSB:DATA_LSB];

    calc_paridade u_paridade (
        .dado_i     (dado),
        .paridade_o (paridade_calc)
    );

    always_comb begin
        estado_d     = estado_q;
        tentativas_d = tentativas_q;
        canais_d     = canais_q;
        atualizado_d = '0;
        erro_d       = erro_q;
        case (estado_q)
            OCIOSO:   estado_d = (pacote_valido && pronto_q) ? VERIFICA : OCIOSO;
            VERIFICA: estado_d = (paridade_calc == paridade_q) ? GRAVA :
                                 (tentativas_q < 3'(MAX_TENTATIVAS - 1)) ? REENVIO : DESCARTA;
            GRAVA: begin
                estado_d                      = OCIOSO;
                canais_d[{addr, 3'b000} +: 8] = dado;
                atualizado_d[addr]            = 1'b1;
                erro_d[addr]                  = 1'b0;
                tentativas_d                  = '0;
            end
            REENVIO: begin
                estado_d     = OCIOSO;
                tentativas_d = tentativas_q + 3'd1;
            end
            DESCARTA: begin
                estado_d     = OCIOSO;
                erro_d[addr] = 1'b1;
                tentativas_d = '0;
            end
            default: estado_d = OCIOSO;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado_q     <= OCIOSO;
            pacote_q     <= '0;
            paridade_q   <= 1'b0;
            tentativas_q <= '0;
            canais_q     <= '0;
            atualizado_q <= '0;
            erro_q       <= '0;
            pronto_q     <= 1'b1;
            reenvio_q    <= 1'b0;
        end else begin
            estado_q     <= estado_d;
            tentativas_q <= tentativas_d;
            canais_q     <= canais_d;
            atualizado_q <= atualizado_d;
            erro_q       <= erro_d;
            pronto_q     <= (estado_d == OCIOSO);
            reenvio_q    <= (estado_d == REENVIO);
            if (pacote_valido && pronto_q) begin
                pacote_q   <= pacote;
                paridade_q <= paridade;
            end
        end
    end

`ifdef CONTADOR_ERROS_EN
    logic [7:0] contagem_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            contagem_q <= '0;
        else if ((estado_q == REENVIO || estado_q == DESCARTA) && contagem_q != 8'hFF)
            contagem_q <= contagem_q + 8'd1;
    end
    assign contagem_erros = contagem_q;
`endif

    assign pacote_pronto     = pronto_q;
    assign solicitar_reenvio = reenvio_q;
    assign saida_canais      = canais_q;
    assign canal_atualizado  = atualizado_q;
    assign erro_persistente  = erro_q;
endmodule

// File: tb/tb_receptor_pacote.sv
// tb_receptor_pacote: scoreboard bench for receptor_pacote against a packet-level reference model.
module tb_receptor_pacote;
    localparam int MAXT = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [10:0] pacote = '0;
    logic        paridade = 1'b0;
    logic        pacote_valido = 1'b0;
    logic        pacote_pronto;
    logic        solicitar_reenvio;
    logic [63:0] saida_canais;
    logic [7:0]  canal_atualizado;
    logic [7:0]  erro_persistente;
`ifdef CONTADOR_ERROS_EN
    logic [7:0]  contagem_erros;
`endif

    receptor_pacote #(.MAX_TENTATIVAS(MAXT)) dut (
        .clk               (clk),
        .rst               (rst),
        .pacote            (pacote),
        .paridade          (paridade),
        .pacote_valido     (pacote_valido),
        .pacote_pronto     (pacote_pronto),
        .solicitar_reenvio (solicitar_reenvio),
        .saida_canais      (saida_canais),
        .canal_atualizado  (canal_atualizado),
`ifdef CONTADOR_ERROS_EN
        .contagem_erros    (contagem_erros),
`endif
        .erro_persistente  (erro_persistente)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  atual;
        logic [63:0] canais;
        logic [7:0]  erro;
        int          reenvios;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int failures = 0;

    // reference model state
    logic [7:0] m_chan [8];
    bit         m_err  [8];
    int         m_fails;
    int         m_bad_cycles;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h @%0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_chan[i] = '0;
            m_err[i]  = 1'b0;
        end
        m_fails = 0;
        m_bad_cycles = 0;
    endtask

    task automatic model_accept(input logic [10:0] p, input logic par);
        exp_t e;
        int a;
        logic [7:0] d;
        a = int'(p[10:8]);
        d = p[7:0];
        e.atual = '0;
        e.reenvios = 0;
        if ((^d) == par) begin
            m_chan[a] = d;
            m_err[a]  = 1'b0;
            m_fails   = 0;
            e.atual   = 8'(1 << a);
        end else begin
            m_bad_cycles++;
            if (m_fails + 1 < MAXT) begin
                m_fails++;
                e.reenvios = 1;
            end else begin
                m_err[a] = 1'b1;
                m_fails  = 0;
            end
        end
        for (int i = 0; i < 8; i++) begin
            e.canais[8*i +: 8] = m_chan[i];
            e.erro[i] = m_err[i];
        end
        exp_q.push_back(e);
    endtask

    // Drives a packet and holds it until the DUT accepts it; returns the accept edge time.
    task automatic send(input logic [10:0] p, input logic par, output time t_acc);
        bit ok;
        pacote = p;
        paridade = par;
        pacote_valido = 1'b1;
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            if (pacote_pronto) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            $display("FAIL accept_timeout actual=pronto_low required=pronto_high");
            failures++;
            checks++;
        end
        model_accept(p, par);
        @(posedge clk);
        t_acc = $time;
        #1;
        pacote_valido = 1'b0;
    endtask

    task automatic drain();
        bit ok;
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0 && pacote_pronto) begin
                ok = 1;
                break;
            end
        end
        chk("drain", 64'(ok), 64'd1);
    endtask

    // Monitor: pronto low marks a packet in flight; its rising edge closes the window.
    bit prev_pr = 1'b1;
    int low_n = 0;
    int reen_n = 0;
    exp_t e_m;
    always @(negedge clk) begin
        if (rst) begin
            prev_pr = 1'b1;
            low_n = 0;
            reen_n = 0;
        end else begin
            if (!pacote_pronto) begin
                low_n++;
                reen_n += int'(solicitar_reenvio);
                chk("atual_busy", 64'(canal_atualizado), 64'd0);
            end else if (!prev_pr) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", 64'd1, 64'd0);
                end else begin
                    e_m = exp_q.pop_front();
                    chk("canal_atualizado", 64'(canal_atualizado), 64'(e_m.atual));
                    chk("saida_canais", saida_canais, e_m.canais);
                    chk("erro_persistente", 64'(erro_persistente), 64'(e_m.erro));
                    chk("reenvio_pulses", 64'(reen_n), 64'(e_m.reenvios));
                    chk("busy_cycles", 64'(low_n), 64'd2);
                end
                low_n = 0;
                reen_n = 0;
            end else begin
                chk("idle_atual", 64'(canal_atualizado), 64'd0);
                chk("idle_reenvio", 64'(solicitar_reenvio), 64'd0);
            end
            prev_pr = pacote_pronto;
        end
    end

    time t0, t1, t2;
    logic [7:0] d;
    logic [2:0] a;

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_pronto", 64'(pacote_pronto), 64'd1);
        chk("rst_reenvio", 64'(solicitar_reenvio), 64'd0);
        chk("rst_canais", saida_canais, 64'd0);
        chk("rst_atual", 64'(canal_atualizado), 64'd0);
        chk("rst_erro", 64'(erro_persistente), 64'd0);

        send(11'h5A5, 1'b0, t0);
        drain();
        chk("t1_ch5", 64'(saida_canais[47:40]), 64'hA5);

        send(11'h101, 1'b0, t0);
        send(11'h101, 1'b1, t0);
        send(11'h101, 1'b0, t0);
        send(11'h101, 1'b1, t0);
        drain();
        chk("t2_ch1", 64'(saida_canais[15:8]), 64'h01);

        for (int i = 0; i < 3; i++) send(11'h203, 1'b1, t0);
        drain();
        chk("t3_erro", 64'(erro_persistente), 64'h04);
        send(11'h203, 1'b0, t0);
        drain();
        chk("t3_clear", 64'(erro_persistente), 64'h00);

        send(11'h377, 1'b0, t0);
        send(11'h488, 1'b0, t1);
        send(11'h699, 1'b0, t2);
        drain();
        chk("t4_gap1", 64'(t1 - t0), 64'd30);
        chk("t4_gap2", 64'(t2 - t1), 64'd30);

        pacote = 11'h7C3;
        paridade = 1'b0;
        pacote_valido = 1'b1;
        @(posedge clk);
        #1;
        pacote_valido = 1'b0;
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("t5_pronto", 64'(pacote_pronto), 64'd1);
        chk("t5_canais", saida_canais, 64'd0);
        chk("t5_atual", 64'(canal_atualizado), 64'd0);
        chk("t5_erro", 64'(erro_persistente), 64'd0);
        chk("t5_reenvio", 64'(solicitar_reenvio), 64'd0);
        exp_q.delete();
        model_reset();
        @(negedge clk);
        #2;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("t5_no_write", saida_canais, 64'd0);

        for (int n = 0; n < 150; n++) begin
            d = 8'($urandom);
            a = 3'($urandom);
            send({a, d}, ($urandom_range(0, 9) < 6) ? ^d : ~^d, t0);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(posedge clk);
            #1;
        end
        drain();

`ifdef CONTADOR_ERROS_EN
        for (int n = 0; n < 300; n++) send(11'h001, 1'b0, t0);
        drain();
        chk("contagem_erros", 64'(contagem_erros), 64'(m_bad_cycles > 255 ? 255 : m_bad_cycles));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
